// File: rtl/pipe_stage_reg_if.sv
// Handshake/payload bundle between pipeline control, the upstream stage and a pipe_stage_reg.
// The master side drives stall/bubble and the upstream payload; the slave side is the register.
interface pipe_stage_reg_if #(
   parameter int unsigned W_DATA  = 64,
   parameter int unsigned N_WORDS = 2,
   parameter int unsigned CNT_W   = 16
);
   localparam int unsigned W_BUS = N_WORDS * W_DATA;

   logic             stall;
   logic             bubble;
   logic [2:0]       in_stat;
   logic [3:0]       in_icode;
   logic             in_cnd;
   logic [3:0]       in_dstE;
   logic [3:0]       in_dstM;
   logic [W_BUS-1:0] in_data;

   logic [2:0]       out_stat;
   logic [3:0]       out_icode;
   logic             out_cnd;
   logic [3:0]       out_dstE;
   logic [3:0]       out_dstM;
   logic [W_BUS-1:0] out_data;
   logic             out_valid;
   logic             exc_held;
   logic             ctl_err;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] bubble_cnt;

   modport master (
      output stall, bubble, in_stat, in_icode, in_cnd, in_dstE, in_dstM, in_data,
      input  out_stat, out_icode, out_cnd, out_dstE, out_dstM, out_data,
      input  out_valid, exc_held, ctl_err, stall_cnt, bubble_cnt
   );

   modport slave (
      input  stall, bubble, in_stat, in_icode, in_cnd, in_dstE, in_dstM, in_data,
      output out_stat, out_icode, out_cnd, out_dstE, out_dstM, out_data,
      output out_valid, exc_held, ctl_err, stall_cnt, bubble_cnt
   );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic Y86-64 inter-stage pipeline register with stall hold, bubble injection,
// exception freeze, sticky stall/bubble conflict flag and saturating activity counters.
module pipe_stage_reg #(
   parameter int unsigned W_DATA        = 64,
   parameter int unsigned N_WORDS       = 2,
   parameter int unsigned CNT_W         = 16,
   parameter bit          FREEZE_ON_EXC = 1'b1,
   parameter logic [2:0]  BUB_STAT      = 3'd0,
   parameter logic [2:0]  AOK_STAT      = 3'd1,
   parameter logic [3:0]  NOP_ICODE     = 4'h1,
   parameter logic [3:0]  RNONE         = 4'hF
) (
   input  logic               clk,
   input  logic               rst,
   pipe_stage_reg_if.slave    bus
);
   localparam int unsigned W_BUS = N_WORDS * W_DATA;

   logic [2:0]       r_stat;
   logic [3:0]       r_icode;
   logic             r_cnd;
   logic [3:0]       r_dstE;
   logic [3:0]       r_dstM;
   logic [W_BUS-1:0] r_data;
   logic             r_valid;
   logic             r_ctl_err;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_bubble_cnt;

   logic             w_exc_held;
   logic             w_do_bubble;
   logic             w_do_hold;
   logic             w_stall_sat;
   logic             w_bubble_sat;

   // Frozen whenever a genuine exception status sits in the register.
   assign w_exc_held   = FREEZE_ON_EXC && (r_stat != AOK_STAT) && (r_stat != BUB_STAT);
   assign w_do_bubble  = !w_exc_held && bus.bubble;
   assign w_do_hold    = !w_exc_held && !bus.bubble && bus.stall;
   assign w_stall_sat  = &r_stall_cnt;
   assign w_bubble_sat = &r_bubble_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stat       <= BUB_STAT;
         r_icode      <= NOP_ICODE;
         r_cnd        <= 1'b0;
         r_dstE       <= RNONE;
         r_dstM       <= RNONE;
         r_data       <= '0;
         r_valid      <= 1'b0;
         r_ctl_err    <= 1'b0;
         r_stall_cnt  <= '0;
         r_bubble_cnt <= '0;
      end else begin
         // Conflict is recorded regardless of freeze so misbehaving control is never masked.
         if (bus.stall && bus.bubble) begin
            r_ctl_err <= 1'b1;
         end

         if (w_do_bubble) begin
            r_stat  <= BUB_STAT;
            r_icode <= NOP_ICODE;
            r_cnd   <= 1'b0;
            r_dstE  <= RNONE;
            r_dstM  <= RNONE;
            r_data  <= '0;
            r_valid <= 1'b0;
            if (!w_bubble_sat) begin
               r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
         end else if (w_do_hold) begin
            if (!w_stall_sat) begin
               r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
         end else if (!w_exc_held) begin
            r_stat  <= bus.in_stat;
            r_icode <= bus.in_icode;
            r_cnd   <= bus.in_cnd;
            r_dstE  <= bus.in_dstE;
            r_dstM  <= bus.in_dstM;
            r_data  <= bus.in_data;
            r_valid <= 1'b1;
         end
      end
   end

   assign bus.out_stat   = r_stat;
   assign bus.out_icode  = r_icode;
   assign bus.out_cnd    = r_cnd;
   assign bus.out_dstE   = r_dstE;
   assign bus.out_dstM   = r_dstM;
   assign bus.out_data   = r_data;
   assign bus.out_valid  = r_valid;
   assign bus.exc_held   = w_exc_held;
   assign bus.ctl_err    = r_ctl_err;
   assign bus.stall_cnt  = r_stall_cnt;
   assign bus.bubble_cnt = r_bubble_cnt;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg: default instance plus a CNT_W=4 instance
// used to exercise counter saturation.
module tb_pipe_stage_reg;
   logic clk;
   logic rst;

   int unsigned n_checks;
   int unsigned n_fail;

   pipe_stage_reg_if #(.W_DATA(64), .N_WORDS(2), .CNT_W(16)) bus ();
   pipe_stage_reg_if #(.W_DATA(64), .N_WORDS(2), .CNT_W(4))  sbus ();

   pipe_stage_reg #(.W_DATA(64), .N_WORDS(2), .CNT_W(16)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   pipe_stage_reg #(.W_DATA(64), .N_WORDS(2), .CNT_W(4)) u_sat (
      .clk (clk),
      .rst (rst),
      .bus (sbus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] st, input logic [3:0] ic, input logic cn,
                        input logic [3:0] de, input logic [3:0] dm, input logic [127:0] d);
      bus.in_stat  = st;
      bus.in_icode = ic;
      bus.in_cnd   = cn;
      bus.in_dstE  = de;
      bus.in_dstM  = dm;
      bus.in_data  = d;
   endtask

   task automatic chk_bubble(input string tag);
      chk({tag, "_stat"},  128'(bus.out_stat),  128'd0);
      chk({tag, "_icode"}, 128'(bus.out_icode), 128'h1);
      chk({tag, "_cnd"},   128'(bus.out_cnd),   128'd0);
      chk({tag, "_dstE"},  128'(bus.out_dstE),  128'hF);
      chk({tag, "_dstM"},  128'(bus.out_dstM),  128'hF);
      chk({tag, "_data"},  bus.out_data,        128'd0);
      chk({tag, "_valid"}, 128'(bus.out_valid), 128'd0);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b0;
      bus.stall = 1'b0;  bus.bubble = 1'b0;
      drive(3'd0, 4'h0, 1'b0, 4'h0, 4'h0, 128'd0);
      sbus.stall = 1'b0; sbus.bubble = 1'b0;
      sbus.in_stat = 3'd1; sbus.in_icode = 4'h0; sbus.in_cnd = 1'b0;
      sbus.in_dstE = 4'h0; sbus.in_dstM = 4'h0; sbus.in_data = 128'd0;

      // Reset asserted mid-cycle.
      #3 rst = 1'b1;
      #1;
      chk_bubble("rst");
      chk("rst_ctl_err", 128'(bus.ctl_err),    128'd0);
      chk("rst_scnt",    128'(bus.stall_cnt),  128'd0);
      chk("rst_bcnt",    128'(bus.bubble_cnt), 128'd0);
      chk("rst_exc",     128'(bus.exc_held),   128'd0);
      tick();
      tick();
      rst = 1'b0;

      // First load.
      drive(3'd1, 4'h6, 1'b1, 4'h3, 4'hF, {64'h10, 64'h20});
      tick();
      chk("ld_stat",  128'(bus.out_stat),  128'd1);
      chk("ld_icode", 128'(bus.out_icode), 128'h6);
      chk("ld_cnd",   128'(bus.out_cnd),   128'd1);
      chk("ld_dstE",  128'(bus.out_dstE),  128'h3);
      chk("ld_dstM",  128'(bus.out_dstM),  128'hF);
      chk("ld_data",  bus.out_data,        128'h0000000000000010_0000000000000020);
      chk("ld_valid", 128'(bus.out_valid), 128'd1);

      // Stall three cycles while upstream moves on.
      bus.stall = 1'b1;
      drive(3'd1, 4'h2, 1'b0, 4'h4, 4'h5, 128'hABCD);
      for (int i = 0; i < 3; i++) tick();
      chk("st_icode", 128'(bus.out_icode), 128'h6);
      chk("st_data",  bus.out_data,        128'h0000000000000010_0000000000000020);
      chk("st_cnt",   128'(bus.stall_cnt), 128'd3);
      bus.stall = 1'b0;
      tick();
      chk("rel_icode", 128'(bus.out_icode), 128'h2);
      chk("rel_dstE",  128'(bus.out_dstE),  128'h4);
      chk("rel_cnt",   128'(bus.stall_cnt), 128'd3);

      // Bubble while holding icode 5.
      drive(3'd1, 4'h5, 1'b1, 4'h7, 4'h8, 128'h55);
      tick();
      chk("h5_icode", 128'(bus.out_icode), 128'h5);
      bus.bubble = 1'b1;
      tick();
      chk_bubble("bub");
      chk("bub_cnt", 128'(bus.bubble_cnt), 128'd1);
      chk("bub_err", 128'(bus.ctl_err),    128'd0);

      // Stall and bubble together: bubble wins, ctl_err sticks.
      bus.bubble = 1'b0;
      tick();
      chk("re_valid", 128'(bus.out_valid), 128'd1);
      bus.stall = 1'b1; bus.bubble = 1'b1;
      tick();
      chk_bubble("cf");
      chk("cf_err",  128'(bus.ctl_err),    128'd1);
      chk("cf_bcnt", 128'(bus.bubble_cnt), 128'd2);
      chk("cf_scnt", 128'(bus.stall_cnt),  128'd3);
      bus.stall = 1'b0; bus.bubble = 1'b0;
      tick();
      chk("cf_err_sticky", 128'(bus.ctl_err),   128'd1);
      chk("cf_after_ic",   128'(bus.out_icode), 128'h5);

      // Exception freeze.
      drive(3'd3, 4'h7, 1'b1, 4'h2, 4'h9, 128'h77);
      tick();
      chk("exc_held", 128'(bus.exc_held), 128'd1);
      chk("exc_stat", 128'(bus.out_stat), 128'd3);
      drive(3'd1, 4'h8, 1'b0, 4'h1, 4'h1, 128'h88);
      tick();
      chk("frz_ld_icode", 128'(bus.out_icode), 128'h7);
      chk("frz_ld_data",  bus.out_data,        128'h77);
      bus.stall = 1'b1;
      tick();
      chk("frz_st_cnt", 128'(bus.stall_cnt), 128'd3);
      bus.stall = 1'b0; bus.bubble = 1'b1;
      tick();
      chk("frz_bub_icode", 128'(bus.out_icode),  128'h7);
      chk("frz_bub_valid", 128'(bus.out_valid),  128'd1);
      chk("frz_bub_cnt",   128'(bus.bubble_cnt), 128'd2);
      bus.bubble = 1'b0;

      // Asynchronous reset clears the freeze before any edge.
      #2 rst = 1'b1;
      #1;
      chk("ar_exc",   128'(bus.exc_held),   128'd0);
      chk("ar_stat",  128'(bus.out_stat),   128'd0);
      chk("ar_err",   128'(bus.ctl_err),    128'd0);
      chk("ar_scnt",  128'(bus.stall_cnt),  128'd0);
      chk("ar_bcnt",  128'(bus.bubble_cnt), 128'd0);
      chk("ar_valid", 128'(bus.out_valid),  128'd0);
      tick();
      rst = 1'b0;

      // Loading a bubble status still counts as a real load.
      drive(3'd0, 4'hC, 1'b0, 4'h6, 4'h6, 128'h1);
      tick();
      chk("bs_valid", 128'(bus.out_valid), 128'd1);
      chk("bs_exc",   128'(bus.exc_held),  128'd0);
      chk("bs_icode", 128'(bus.out_icode), 128'hC);

      // Counter saturation on the 4-bit instance.
      sbus.stall = 1'b1;
      for (int i = 0; i < 14; i++) tick();
      chk("sat_14", 128'(sbus.stall_cnt), 128'hE);
      tick();
      chk("sat_15", 128'(sbus.stall_cnt), 128'hF);
      for (int i = 0; i < 5; i++) tick();
      chk("sat_20", 128'(sbus.stall_cnt), 128'hF);
      sbus.stall = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
